tilemap_writer: RTL and testbench
=================================

# tilemap_writer

Fills the tile-map RAM that the screen-to-tile address transformer reads during scan-out. After reset it clears the whole map to walkable tiles. On each scroll request it then writes one full row of pseudo-random tile codes at the requested row. Its address arithmetic matches the read side exactly (address = row × COLS + col), so both ends agree on the memory layout.

## Interface
Parameters:
- HSIZE, 640, visible width in pixels
- VSIZE, 480, visible height in pixels
- IWIDTH, 5, log2 of tile edge in pixels
- AWIDTH, 9, tile-map RAM address width
- DWIDTH, 2, tile code width
- SEED, 16'hACE1, LFSR reset value; must be nonzero
- Derived: COLS = HSIZE>>IWIDTH (20), ROWS = VSIZE>>IWIDTH (15), RWIDTH = $clog2(ROWS) (4)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  row-write request, sampled each cycle
- row  in  RWIDTH  target tile row, sampled with start
- busy  out  1  high during INIT or ROW
- done  out  1  one-cycle pulse when a row write completes
- we  out  1  RAM write enable
- waddr  out  AWIDTH  RAM write address
- wdata  out  DWIDTH  RAM write data

## Operation
- **States:** INIT, IDLE, ROW, DONE.
- **Reset values:**
  - state = INIT; busy = 1; done, we, waddr, wdata = 0
  - LFSR = SEED; column counter = 0; init address counter = 0
- **INIT:**
  - Writes wdata = 0 to addresses 0 … ROWS×COLS−1 (0 … 299), one per cycle, in ascending order.
  - The LFSR does not advance.
  - start is ignored.
  - After the last address, go to IDLE.
- **IDLE:**
  - busy = 0; we = 0.
  - start = 1 with row < ROWS: latch row, clear the column counter, go to ROW.
  - start = 1 with row ≥ ROWS: ignored; the block stays in IDLE and no done is produced.
- **ROW:**
  - Each cycle: we = 1, waddr = row×COLS + col, wdata = lfsr[DWIDTH−1:0].
  - After each write, the LFSR advances once and col increments.
  - After the write with col = COLS−1, go to DONE.
- **DONE:** done = 1 and busy = 0 for one cycle, then IDLE. start is ignored in this cycle.
- **LFSR:**
  - 16-bit Fibonacci, taps 16, 14, 13, 11.
  - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- **Arithmetic:**
  - row×COLS + col is computed at full precision, then truncated to AWIDTH.
  - The instantiating design must ensure ROWS×COLS ≤ 2^AWIDTH.
- **start during busy:** dropped, not queued.
- **Reset mid-operation:** any state returns to reset values immediately. INIT restarts from address 0; the partially written row is abandoned.

## Timing
- RAM outputs (we, waddr, wdata) are registered.
- **INIT:** first write is visible in the first cycle after rst_n deasserts. INIT lasts ROWS×COLS cycles (300), then busy falls.
- **Row request:** start accepted at edge N produces:
  - we high in cycles N+1 … N+COLS (N+20)
  - done pulse in cycle N+COLS+1
- busy is high from N+1 through N+COLS.
- Back-to-back rows: the earliest next accepted start is at cycle N+COLS+2, so row throughput is one row per COLS+2 cycles.
- No combinational path from start or row to any output.

## Configuration
- **TILEMAP_WRITER_SAFE_PATH_EN defined:**
  - A path column register (reset COLS/2 = 10) is held.
  - In ROW, the tile at col == path gets wdata = 0 instead of the LFSR value; the LFSR still advances.
  - On entering DONE, path moves by lfsr[1:0]: 00 → −1, 01 → +1, otherwise unchanged. The result is clamped to 0 … COLS−1.
  - This guarantees a walkable column in every generated row.
- **Macro not defined:** no path register. Every ROW write uses lfsr[DWIDTH−1:0]. The timing above is identical either way.

## Test plan
- Reset, then release rst_n → 300 consecutive writes, addresses 0 … 299, wdata 0, busy high throughout. busy falls and no done pulse occurs.
- After INIT, start with row = 3 → 20 writes to addresses 60 … 79, wdata equal to the low 2 bits of the LFSR sequence from 0xACE1, done pulses exactly once, 21 cycles after start.
- Extra start pulses during ROW, plus start with row = 15 in IDLE → no extra writes, no done, LFSR unchanged.
- Assert rst_n low in the middle of a row-14 write (addresses 280 … 299) → outputs are zero immediately; after release, INIT restarts at address 0 and the LFSR equals 0xACE1 again.
- Two rows with row = 0 then row = 14, second start at earliest legal cycle → 20 writes each to 0 … 19 and 280 … 299, with two done pulses 22 cycles apart.
- With TILEMAP_WRITER_SAFE_PATH_EN, 50 consecutive rows → each row has wdata 0 at the model's path column; the path column changes by at most 1 per row and stays within 0 … 19.

Source files
------------

// File: rtl/tilemap_writer.sv
// Tile-map RAM writer: clears the map after reset, then writes one pseudo-random row per request.
// Optional walkable-path column: define TILEMAP_WRITER_SAFE_PATH_EN.
module tilemap_writer #(
  parameter int          HSIZE  = 640,
  parameter int          VSIZE  = 480,
  parameter int          IWIDTH = 5,
  parameter int          AWIDTH = 9,
  parameter int          DWIDTH = 2,
  parameter logic [15:0] SEED   = 16'hACE1,
  localparam int         COLS   = HSIZE >> IWIDTH,
  localparam int         ROWS   = VSIZE >> IWIDTH,
  localparam int         RWIDTH = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RWIDTH-1:0] row,
  output logic              busy,
  output logic              done,
  output logic              we,
  output logic [AWIDTH-1:0] waddr,
  output logic [DWIDTH-1:0] wdata
);

  // state  | meaning
  // S_INIT | clearing every map entry to tile code 0
  // S_IDLE | waiting for a row request
  // S_ROW  | writing one row of LFSR tile codes
  // S_DONE | one-cycle completion pulse
  localparam int NTILES  = ROWS * COLS;
  localparam int CWIDTH  = $clog2(COLS);
  localparam int ICWIDTH = $clog2(NTILES);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ROW, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CWIDTH-1:0]    col_q, col_d;
  logic [ICWIDTH-1:0]   icnt_q, icnt_d;
  logic [RWIDTH-1:0]    row_q, row_d;
  logic [15:0]          lfsr_q, lfsr_d, lfsr_nx;
  logic                 busy_d, done_d, we_d;
  logic [AWIDTH-1:0]    waddr_d, row_addr;
  logic [DWIDTH-1:0]    wdata_d;
`ifdef TILEMAP_WRITER_SAFE_PATH_EN
  logic [CWIDTH-1:0]    path_q, path_d;
  int                   path_step;
`endif

  assign lfsr_nx  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // Full-precision product, truncated to the RAM address width (same layout as the read side).
  assign row_addr = AWIDTH'(32'(row_q) * 32'(COLS) + 32'(col_q));

  // Outputs are registered from the action of the current state, so they trail state by one cycle.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    icnt_d  = icnt_q;
    row_d   = row_q;
    lfsr_d  = lfsr_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
`ifdef TILEMAP_WRITER_SAFE_PATH_EN
    path_d    = path_q;
    path_step = 0;
`endif
    case (state_q)
      S_INIT: begin
        busy_d  = 1'b1;
        we_d    = 1'b1;
        waddr_d = AWIDTH'(icnt_q);
        if (icnt_q == ICWIDTH'(NTILES - 1)) state_d = S_IDLE;
        else icnt_d = icnt_q + 1'b1;
      end
      S_IDLE: begin
        if (start && (32'(row) < 32'(ROWS))) begin
          row_d   = row;
          col_d   = '0;
          state_d = S_ROW;
        end
      end
      S_ROW: begin
        busy_d  = 1'b1;
        we_d    = 1'b1;
        waddr_d = row_addr;
        wdata_d = lfsr_q[DWIDTH-1:0];
        lfsr_d  = lfsr_nx;
`ifdef TILEMAP_WRITER_SAFE_PATH_EN
        if (col_q == path_q) wdata_d = '0;
`endif
        if (col_q == CWIDTH'(COLS - 1)) begin
          state_d = S_DONE;
`ifdef TILEMAP_WRITER_SAFE_PATH_EN
          path_step = int'(path_q);
          if (lfsr_q[1:0] == 2'b00) path_step = path_step - 1;
          else if (lfsr_q[1:0] == 2'b01) path_step = path_step + 1;
          if (path_step < 0) path_step = 0;
          else if (path_step > COLS - 1) path_step = COLS - 1;
          path_d = CWIDTH'(path_step);
`endif
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      col_q   <= '0;
      icnt_q  <= '0;
      row_q   <= '0;
      lfsr_q  <= SEED;
      busy    <= 1'b1;
      done    <= 1'b0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
`ifdef TILEMAP_WRITER_SAFE_PATH_EN
      path_q  <= CWIDTH'(COLS / 2);
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      icnt_q  <= icnt_d;
      row_q   <= row_d;
      lfsr_q  <= lfsr_d;
      busy    <= busy_d;
      done    <= done_d;
      we      <= we_d;
      waddr   <= waddr_d;
      wdata   <= wdata_d;
`ifdef TILEMAP_WRITER_SAFE_PATH_EN
      path_q  <= path_d;
`endif
    end
  end

endmodule

// File: tb/tb_tilemap_writer.sv
// Self-checking bench for tilemap_writer: scoreboard of expected RAM writes plus done timing checks.
// Build with TILEMAP_WRITER_SAFE_PATH_EN defined to model the walkable path column.
module tb_tilemap_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] row = 4'd0;
  logic       busy, done, we;
  logic [8:0] waddr;
  logic [1:0] wdata;

  tilemap_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row(row),
    .busy(busy), .done(done), .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] addr;
    logic [1:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] row;
    bit         valid;
  } vec_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          last_done = -1;
  int          prev_done = -1;
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_path = 10;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_init();
    wr_t w;
    for (int i = 0; i < 300; i++) begin
      w.addr = 9'(i);
      w.data = 2'b00;
      exp_q.push_back(w);
    end
  endtask

  task automatic push_row(input int r);
    wr_t w;
    for (int c = 0; c < 20; c++) begin
      w.addr = 9'(r * 20 + c);
      w.data = m_lfsr[1:0];
`ifdef TILEMAP_WRITER_SAFE_PATH_EN
      if (c == m_path) w.data = 2'b00;
      if (c == 19) begin
        if (m_lfsr[1:0] == 2'b00) m_path = m_path - 1;
        else if (m_lfsr[1:0] == 2'b01) m_path = m_path + 1;
        if (m_path < 0) m_path = 0;
        if (m_path > 19) m_path = 19;
      end
`endif
      exp_q.push_back(w);
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // Single request: start for one cycle, then check write count and done timing.
  task automatic do_row(input logic [3:0] r, input bit valid);
    int d0, w0, n;
    d0 = done_cnt;
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    row   = r;
    n     = cyc + 1;
    if (valid) push_row(int'(r));
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("row_done_count", done_cnt - d0, valid ? 1 : 0);
    chk("row_write_count", wr_cnt - w0, valid ? 20 : 0);
    if (valid) chk("row_done_cycle", last_done - n, 21);
    chk("row_queue_empty", exp_q.size(), 0);
  endtask

  initial begin : cycle_count
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (we) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", int'(waddr), -1);
          end else begin
            e = exp_q.pop_front();
            chk("waddr", int'(waddr), int'(e.addr));
            chk("wdata", int'(wdata), int'(e.data));
          end
          chk("busy_during_write", int'(busy), 1);
        end
        if (done) begin
          done_cnt++;
          prev_done = last_done;
          last_done = cyc;
          chk("busy_during_done", int'(busy), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[7];
    int   d0, w0, n;

    vecs[0] = '{row: 4'd3,  valid: 1'b1};
    vecs[1] = '{row: 4'd0,  valid: 1'b1};
    vecs[2] = '{row: 4'd14, valid: 1'b1};
    vecs[3] = '{row: 4'd15, valid: 1'b0};
    vecs[4] = '{row: 4'd7,  valid: 1'b1};
    vecs[5] = '{row: 4'd15, valid: 1'b0};
    vecs[6] = '{row: 4'd9,  valid: 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 1);
    chk("rst_we", int'(we), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wdata", int'(wdata), 0);

    // INIT clear; a start during INIT must be ignored
    push_init();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b1;
    row   = 4'd2;
    @(negedge clk);
    start = 1'b0;
    drain("init_drain", 400);
    @(negedge clk);
    chk("init_busy_fall", int'(busy), 0);
    chk("init_write_count", wr_cnt, 300);
    chk("init_no_done", done_cnt, 0);

    foreach (vecs[i]) do_row(vecs[i].row, vecs[i].valid);

    // start held high through the whole row and the DONE cycle
    d0 = done_cnt;
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    row   = 4'd5;
    n     = cyc + 1;
    push_row(5);
    repeat (21) begin
      @(negedge clk);
      row = 4'($urandom_range(0, 15));
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_done_count", done_cnt - d0, 1);
    chk("hold_write_count", wr_cnt - w0, 20);
    chk("hold_done_cycle", last_done - n, 21);

    // back-to-back rows at the earliest legal restart
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    row   = 4'd0;
    push_row(0);
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    start = 1'b1;
    row   = 4'd14;
    push_row(14);
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_done_gap", last_done - prev_done, 22);
    chk("b2b_queue_empty", exp_q.size(), 0);

    for (int k = 0; k < 50; k++) do_row(4'($urandom_range(0, 14)), 1'b1);

    // reset in the middle of a row-14 write
    @(negedge clk);
    start = 1'b1;
    row   = 4'd14;
    push_row(14);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", int'(we), 0);
    chk("midrst_waddr", int'(waddr), 0);
    chk("midrst_wdata", int'(wdata), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 1);
    exp_q.delete();
    m_lfsr = 16'hACE1;
    m_path = 10;
    repeat (2) @(negedge clk);
    w0 = wr_cnt;
    d0 = done_cnt;
    push_init();
    rst_n = 1'b1;
    drain("reinit_drain", 400);
    @(negedge clk);
    chk("reinit_busy_fall", int'(busy), 0);
    chk("reinit_write_count", wr_cnt - w0, 300);
    chk("reinit_no_done", done_cnt - d0, 0);

    // LFSR restarted from its seed
    do_row(4'd3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
